// File: rtl/p_det_selector_pkg.sv
// Shared types for the CLM parameter-index selector: index type, legal range
// and the selector state encoding.
package p_det_selector_pkg;

  typedef logic [4:0] p_det_t;

  localparam p_det_t P_DET_MIN = 5'd1;
  localparam p_det_t P_DET_MAX = 5'd30;

  // Encoding is {p_det_valid, pend_valid}, so the flags decode straight off the state.
  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    PEND   = 2'b01,
    ACTIVE = 2'b10,
    FULL   = 2'b11
  } p_sel_state_t;

  // Single unsigned compare: 0 wraps to 31 after the subtract, 31 lands on 30.
  function automatic logic p_det_in_range(input p_det_t v);
    p_det_t off;
    off = v - P_DET_MIN;
    return off <= (P_DET_MAX - P_DET_MIN);
  endfunction

endpackage

// File: rtl/p_det_selector.sv
// Draws p_det uniformly from 1..30 by rejection sampling on 5-bit entropy words,
// holding one pre-drawn index in reserve so a refresh normally costs one cycle.
module p_det_selector
  import p_det_selector_pkg::*;
#(
  parameter int unsigned MAX_REJ = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rnd_valid,
  input  logic [4:0] rnd_data,
  output logic       rnd_ready,
  input  logic       refresh,
  output p_det_t     p_det,
  output logic       p_det_valid,
  output logic       rej_err
);

  localparam int unsigned REJ_W = $clog2(MAX_REJ + 1);

  p_sel_state_t     state;
  p_det_t           pend;
  logic [REJ_W-1:0] rej_cnt;
  logic             accept;
  logic             word_ok;
  logic             take;

  assign p_det_valid = state[1];
  assign rnd_ready   = !state[0] && !rej_err;
  assign accept      = rnd_valid && rnd_ready;
  assign word_ok     = p_det_in_range(rnd_data);
  assign take        = accept && word_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      p_det   <= P_DET_MIN;
      pend    <= P_DET_MIN;
      rej_cnt <= '0;
      rej_err <= 1'b0;
    end else begin
      if (accept) begin
        if (word_ok) begin
          rej_cnt <= '0;
        end else if (rej_cnt != REJ_W'(MAX_REJ)) begin
          rej_cnt <= rej_cnt + 1'b1;
          if (rej_cnt == REJ_W'(MAX_REJ - 1)) rej_err <= 1'b1;
        end
      end

      case (state)
        EMPTY: begin
          if (take) begin
            pend  <= rnd_data;
            state <= PEND;
          end
        end
        PEND: begin
          p_det <= pend;
          state <= ACTIVE;
        end
        ACTIVE: begin
          // A refresh coinciding with a fresh word skips EMPTY and parks the word.
          if (take) begin
            pend  <= rnd_data;
            state <= refresh ? PEND : FULL;
          end else if (refresh) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (refresh) begin
            p_det <= pend;
            state <= ACTIVE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
